// File: rtl/sd_serializer.sv
// Wide-to-narrow serializer: splits one parallel word into NUM_SEG segments, LSB first,
// with an end flag on the last segment. A single hold register gives full-rate streaming.
module sd_serializer #(
    parameter int PARA_WIDTH = 63,
    parameter int SER_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PARA_WIDTH-1:0] c_data,
    input  logic                  c_srdy,
    output logic                  c_drdy,
    output logic [SER_WIDTH-1:0]  p_data,
    output logic                  p_ef,
    output logic                  p_srdy,
    input  logic                  p_drdy
);

    localparam int NUM_SEG = (PARA_WIDTH + SER_WIDTH - 1) / SER_WIDTH;
    localparam int SEG_SZ  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int TOT_W   = NUM_SEG * SER_WIDTH;
    localparam logic [SEG_SZ-1:0] LAST_SEG = SEG_SZ'(NUM_SEG - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                              state_q, state_d;
    logic [SEG_SZ-1:0]                   seg_q, seg_d;
    logic [NUM_SEG-1:0][SER_WIDTH-1:0]   hold_q, hold_d;
    logic                                is_last;
    logic [TOT_W-1:0]                    load_word;

    // Zero-extend so the unused top bits of the last segment always read 0.
    assign load_word = TOT_W'(c_data);
    assign is_last   = (seg_q == LAST_SEG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seg_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (c_srdy) begin
                    state_d = SEND;
                    seg_d   = '0;
                    hold_d  = load_word;
                end
            end
            SEND: begin
                if (p_drdy) begin
                    if (is_last) begin
                        // Reload on the cycle the last segment leaves: no bubble.
                        if (c_srdy) begin
                            seg_d  = '0;
                            hold_d = load_word;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        seg_d = seg_q + SEG_SZ'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_drdy = ~reset & ((state_q == IDLE) | (is_last & p_drdy));
        p_srdy = (state_q == SEND);
        p_ef   = (state_q == SEND) & is_last;
        p_data = hold_q[seg_q];
    end

endmodule

// File: tb/tb_sd_serializer.sv
// Directed checks of sd_serializer (3-segment and 1-segment builds) plus a
// randomized stream reassembled against a queue of accepted words.
module tb_sd_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] c_data;
    logic        c_srdy, c_drdy;
    logic [7:0]  p_data;
    logic        p_ef, p_srdy, p_drdy;

    logic [7:0]  c1_data;
    logic        c1_srdy, c1_drdy;
    logic [7:0]  p1_data;
    logic        p1_ef, p1_srdy, p1_drdy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sd_serializer #(.PARA_WIDTH(20), .SER_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .c_data(c_data), .c_srdy(c_srdy), .c_drdy(c_drdy),
        .p_data(p_data), .p_ef(p_ef), .p_srdy(p_srdy), .p_drdy(p_drdy));

    sd_serializer #(.PARA_WIDTH(8), .SER_WIDTH(8)) u_one (
        .clk(clk), .reset(reset), .c_data(c1_data), .c_srdy(c1_srdy), .c_drdy(c1_drdy),
        .p_data(p1_data), .p_ef(p1_ef), .p_srdy(p1_srdy), .p_drdy(p1_drdy));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input string tag, input logic [7:0] d, input logic ef);
        #1;
        chk({tag, "_srdy"}, 32'(p_srdy), 32'd1);
        chk({tag, "_data"}, 32'(p_data), 32'(d));
        chk({tag, "_ef"},   32'(p_ef),   32'(ef));
    endtask

    logic [7:0] exp2 [6] = '{8'h45, 8'h23, 8'h01, 8'h9A, 8'h78, 8'h06};
    logic       ef2  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [19:0] sentq [$];
        logic [23:0] acc;
        logic [19:0] w;
        int          segi;
        int          sent;
        int          words;

        reset = 1'b1; c_data = '0; c_srdy = 1'b0; p_drdy = 1'b0;
        c1_data = '0; c1_srdy = 1'b0; p1_drdy = 1'b0;
        tick(); tick();
        chk("rst_srdy", 32'(p_srdy), 0);
        chk("rst_ef",   32'(p_ef),   0);
        chk("rst_data", 32'(p_data), 0);
        chk("rst_drdy", 32'(c_drdy), 0);
        reset = 1'b0;
        #1 chk("post_rst_drdy", 32'(c_drdy), 1);

        // Basic word
        c_data = 20'hABCDE; c_srdy = 1'b1; p_drdy = 1'b1;
        tick(); c_srdy = 1'b0;
        seg("b0", 8'hDE, 1'b0); chk("b0_drdy", 32'(c_drdy), 0); tick();
        seg("b1", 8'hBC, 1'b0); tick();
        seg("b2", 8'h0A, 1'b1); chk("b2_drdy", 32'(c_drdy), 1); tick();
        chk("b_idle", 32'(p_srdy), 0);

        // Back-to-back words with c_srdy held
        c_data = 20'h12345; c_srdy = 1'b1;
        tick(); c_data = 20'h6789A;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) c_srdy = 1'b0;
            seg($sformatf("bb%0d", i), exp2[i], ef2[i]);
            if (i == 2) chk("bb_reload", 32'(c_drdy), 1);
            tick();
        end
        chk("bb_idle", 32'(p_srdy), 0);

        // Backpressure on segment 1
        c_data = 20'hABCDE; c_srdy = 1'b1;
        tick(); c_srdy = 1'b0;
        seg("bp0", 8'hDE, 1'b0); tick();
        p_drdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seg($sformatf("bps%0d", i), 8'hBC, 1'b0);
            chk("bps_drdy", 32'(c_drdy), 0);
            tick();
        end
        p_drdy = 1'b1;
        seg("bp1", 8'hBC, 1'b0); tick();
        seg("bp2", 8'h0A, 1'b1); tick();

        // Reset mid-word
        c_data = 20'hABCDE; c_srdy = 1'b1;
        tick(); c_srdy = 1'b0;
        seg("rm0", 8'hDE, 1'b0); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        #1;
        chk("rm_srdy", 32'(p_srdy), 0);
        chk("rm_ef",   32'(p_ef),   0);
        chk("rm_data", 32'(p_data), 0);
        chk("rm_drdy", 32'(c_drdy), 1);
        c_data = 20'h12345; c_srdy = 1'b1;
        tick(); c_srdy = 1'b0;
        seg("rr0", 8'h45, 1'b0); tick();
        seg("rr1", 8'h23, 1'b0); tick();
        seg("rr2", 8'h01, 1'b1); tick();

        // Single-segment build
        c1_data = 8'h5A; c1_srdy = 1'b1; p1_drdy = 1'b1;
        #1 chk("one_drdy", 32'(c1_drdy), 1);
        tick(); c1_srdy = 1'b0;
        chk("one_srdy", 32'(p1_srdy), 1);
        chk("one_data", 32'(p1_data), 32'h5A);
        chk("one_ef",   32'(p1_ef),   1);
        tick();
        chk("one_idle", 32'(p1_srdy), 0);

        // Random stream, reassembled and compared in order
        sent = 0; words = 0; segi = 0; acc = '0;
        for (int cyc = 0; cyc < 4000 && (sent < 200 || sentq.size() > 0); cyc++) begin
            c_srdy = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            c_data = 20'($urandom);
            p_drdy = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (c_srdy && c_drdy) begin
                sentq.push_back(c_data);
                sent++;
            end
            if (p_srdy && p_drdy) begin
                acc[segi*8 +: 8] = p_data;
                chk("loop_ef", 32'(p_ef), 32'(segi == 2));
                if (segi == 2 || p_ef) begin
                    w = (sentq.size() > 0) ? sentq.pop_front() : 20'hxxxxx;
                    chk("loop_word", 32'(acc), {12'h0, w});
                    words++;
                    segi = 0; acc = '0;
                end else begin
                    segi++;
                end
            end
            tick();
        end
        chk("loop_sent",  32'(sent),  200);
        chk("loop_words", 32'(words), 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
